// File: rtl/hv_rotator.sv
// hv_rotator: multi-cycle circular shift (rho^k permutation) of a hypervector.
// Latency: ceil(amt/STEP) enabled cycles after accept (amt=0 -> valid the next cycle).
// Backpressure: one request in flight; in_ready low until the result leaves DONE.
//
// Ports:
//   clk, nrst (async, active-high)  - clock and reset
//   en, clr                         - progress enable, synchronous abort
//   in_valid/in_ready/in_hv/in_amt/in_dir - request handshake and payload
//   out_valid/out_ready/out_hv      - result handshake and payload
//   busy                            - request in SHIFT or DONE
module hv_rotator #(
  parameter int HV_DIM = 1024,
  parameter int STEP   = 1,
  parameter int AMT_W  = $clog2(HV_DIM)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HV_DIM-1:0] in_hv,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              in_dir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HV_DIM-1:0] out_hv,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

  state_e             state_q, state_d;
  logic [HV_DIM-1:0]  work_q, work_d;
  logic [AMT_W-1:0]   rem_q, rem_d;
  logic               dir_q, dir_d;

  logic [AMT_W-1:0]   step_s;
  logic [HV_DIM-1:0]  rot_hv;

  // Barrel rotate by 0..STEP positions. Only the step value selects a tap,
  // so the mux is STEP+1 wide regardless of HV_DIM.
  function automatic logic [HV_DIM-1:0] rot_by(input logic [HV_DIM-1:0] x,
                                               input logic [AMT_W-1:0]  s,
                                               input logic              left);
    logic [2*HV_DIM-1:0] dbl;
    logic [HV_DIM-1:0]   res;
    res = x;
    for (int k = 1; k <= STEP; k++) begin
      if (s == AMT_W'(k)) begin
        if (left) begin
          dbl = {x, x} << k;
          res = dbl[2*HV_DIM-1:HV_DIM];
        end else begin
          dbl = {x, x} >> k;
          res = dbl[HV_DIM-1:0];
        end
      end
    end
    return res;
  endfunction

  // Step this cycle is min(remaining, STEP) so the final step lands exactly.
  assign step_s = (rem_q < STEP_A) ? rem_q : STEP_A;
  assign rot_hv = rot_by(work_q, step_s, dir_q);

  assign in_ready  = (state_q == ST_IDLE) && en && !nrst;
  assign out_valid = (state_q == ST_DONE);
  assign out_hv    = work_q;
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    if (clr) begin
      // Abort wins over every handshake; working register is left as is.
      state_d = ST_IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            work_d  = in_hv;
            rem_d   = in_amt;
            dir_d   = in_dir;
            state_d = (in_amt == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (en) begin
            work_d = rot_hv;
            rem_d  = rem_q - step_s;
            if (rem_q == step_s) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          // Output handshake deliberately ignores en.
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
    end
  end

  a_out_hold: assert property (@(posedge clk) disable iff (nrst)
    (out_valid && !out_ready) |=> $stable(out_hv));

  a_state_legal: assert property (@(posedge clk) disable iff (nrst)
    (state_q == ST_IDLE) || (state_q == ST_SHIFT) || (state_q == ST_DONE));

endmodule

// File: tb/tb_hv_rotator.sv
// tb_hv_rotator: drives a STEP=4 and a STEP=1 rotator (HV_DIM=16) with shared stimulus.
// Latency: results compared against an index-arithmetic rotation model.
// Backpressure: exercised via out_ready hold-off and en stalls.
module tb_hv_rotator;

  logic        clk;
  logic        nrst;
  logic        en;
  logic        clr;
  logic        in_valid;
  logic [15:0] in_hv;
  logic [3:0]  in_amt;
  logic        in_dir;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_busy;
  logic [15:0] a_out_hv;
  logic        b_in_ready, b_out_valid, b_busy;
  logic [15:0] b_out_hv;

  int n_tests = 0;
  int n_fail  = 0;

  hv_rotator #(.HV_DIM(16), .STEP(4)) u_dut_s4 (
    .clk(clk), .nrst(nrst), .en(en), .clr(clr),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_hv(in_hv),
    .in_amt(in_amt), .in_dir(in_dir),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_hv(a_out_hv),
    .busy(a_busy)
  );

  hv_rotator #(.HV_DIM(16), .STEP(1)) u_dut_s1 (
    .clk(clk), .nrst(nrst), .en(en), .clr(clr),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_hv(in_hv),
    .in_amt(in_amt), .in_dir(in_dir),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_hv(b_out_hv),
    .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Right: new[i] = old[(i+amt) mod 16]; left: new[i] = old[(i-amt) mod 16].
  function automatic logic [15:0] rot_model(input logic [15:0] hv, input int amt, input logic dir);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      if (!dir) r[i] = hv[(i + amt) % 16];
      else      r[i] = hv[(i - amt + 16) % 16];
    end
    return r;
  endfunction

  // Called and returns at #1 after a rising edge with both DUTs idle.
  // stall: en low for that many edges starting with the second edge after accept.
  // bp: extra cycles out_ready stays low after both results are present.
  task automatic do_req(input logic [15:0] hv, input int amt, input logic dir,
                        input int stall, input int bp, input string tag);
    logic [15:0] exp;
    int la, lb, ea, eb, k, ca;
    exp = rot_model(hv, amt, dir);
    ca  = (amt + 3) / 4;
    ea  = ca  + ((ca  >= 2) ? stall : 0);
    eb  = amt + ((amt >= 2) ? stall : 0);
    out_ready = (bp == 0);
    en        = 1'b1;
    in_valid  = 1'b1;
    in_hv     = hv;
    in_amt    = 4'(amt);
    in_dir    = dir;
    chk({tag, "/acc_rdy"}, {30'd0, a_in_ready, b_in_ready}, 32'd3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_hv    = 16'($urandom);
    in_amt   = 4'($urandom);
    in_dir   = 1'($urandom);
    la = -1; lb = -1; k = 0;
    while (k < 200) begin
      if (la < 0) begin
        if (a_out_valid) begin
          la = k;
          chk({tag, "/a_hv"}, {16'd0, a_out_hv}, {16'd0, exp});
        end else begin
          chk({tag, "/a_wait"}, {30'd0, a_in_ready, a_busy}, 32'd1);
        end
      end else if (bp > 0) begin
        chk({tag, "/a_hold"}, {15'd0, a_out_valid, a_out_hv}, {15'd0, 1'b1, exp});
      end
      if (lb < 0) begin
        if (b_out_valid) begin
          lb = k;
          chk({tag, "/b_hv"}, {16'd0, b_out_hv}, {16'd0, exp});
        end else begin
          chk({tag, "/b_wait"}, {30'd0, b_in_ready, b_busy}, 32'd1);
        end
      end else if (bp > 0) begin
        chk({tag, "/b_hold"}, {15'd0, b_out_valid, b_out_hv}, {15'd0, 1'b1, exp});
      end
      if (la >= 0 && lb >= 0 && k >= ((la > lb) ? la : lb) + bp) break;
      en = !(stall > 0 && k >= 1 && k <= stall);
      @(posedge clk); #1;
      k++;
    end
    en = 1'b1;
    chk({tag, "/a_lat"}, la, ea);
    chk({tag, "/b_lat"}, lb, eb);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "/idle"},
        {26'd0, a_out_valid, b_out_valid, a_in_ready, b_in_ready, a_busy, b_busy},
        32'b001100);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b1; en = 1'b1; clr = 1'b0; in_valid = 1'b0;
    in_hv = '0; in_amt = '0; in_dir = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst/ctl", {26'd0, a_out_valid, b_out_valid, a_in_ready, b_in_ready, a_busy, b_busy}, 32'd0);
    chk("rst/hv", {a_out_hv, b_out_hv}, 32'd0);
    nrst = 1'b0;
    #1;
    chk("rst/rel_rdy", {30'd0, a_in_ready, b_in_ready}, 32'd3);
    @(posedge clk); #1;

    // Directed cases
    do_req(16'h0001, 1,  1'b0, 0, 0, "r1");
    do_req(16'h0001, 6,  1'b1, 0, 0, "l6");
    do_req(16'h0001, 15, 1'b0, 0, 0, "r15");
    do_req(16'hA5C3, 0,  1'b0, 0, 5, "z0bp");
    do_req(16'h3C91, 8,  1'b1, 3, 0, "stall");

    // Abort during SHIFT
    in_valid = 1'b1; in_hv = 16'h1234; in_amt = 4'd12; in_dir = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr/idle", {26'd0, a_out_valid, b_out_valid, a_busy, b_busy, a_in_ready, b_in_ready}, 32'b000011);
    for (int i = 0; i < 16; i++) begin
      chk("clr/noval", {30'd0, a_out_valid, b_out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    do_req(16'h00F0, 12, 1'b0, 0, 0, "postclr");

    // clr beats a simultaneous request in IDLE
    in_valid = 1'b1; in_hv = 16'hBEEF; in_amt = 4'd3; clr = 1'b1;
    chk("clrreq/rdy", {30'd0, a_in_ready, b_in_ready}, 32'd3);
    @(posedge clk); #1;
    in_valid = 1'b0; clr = 1'b0;
    chk("clrreq/noacc", {28'd0, a_busy, b_busy, a_out_valid, b_out_valid}, 32'd0);

    // Reset while holding a result in DONE
    out_ready = 1'b0;
    in_valid = 1'b1; in_hv = 16'h0F0F; in_amt = 4'd3; in_dir = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rstdone/pre", {28'd0, a_out_valid, b_out_valid, a_out_hv == 16'h7878, b_out_hv == 16'h7878}, 32'hF);
    nrst = 1'b1;
    #1;
    chk("rstdone/hv", {a_out_hv, b_out_hv}, 32'd0);
    chk("rstdone/ctl", {26'd0, a_out_valid, b_out_valid, a_in_ready, b_in_ready, a_busy, b_busy}, 32'd0);
    @(posedge clk); #1;
    chk("rstdone/hold_rdy", {30'd0, a_in_ready, b_in_ready}, 32'd0);
    nrst = 1'b0; out_ready = 1'b1;
    #1;
    chk("rstdone/rel", {30'd0, a_in_ready, b_in_ready}, 32'd3);
    @(posedge clk); #1;

    // Randomized requests
    for (int n = 0; n < 1000; n++) begin
      do_req(16'($urandom), int'($urandom_range(0, 15)), 1'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
